// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the decade counter family.
// Contents:
//   DIGIT_W      - bits per BCD decade
//   BCD_MAX      - largest legal decade value (9)
//   BCD_ZERO     - decade value zero
//   bcd_digit_t  - one 4-bit decade
//   is_bcd_digit - true when a nibble is a legal decimal digit (0..9)
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   function automatic logic is_bcd_digit(input bcd_digit_t d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decade of the BCD down counter.
// Ports:
//   clk     - clock, rising edge
//   clr     - asynchronous active-high reset, forces the digit to 0
//   load    - synchronous load of ld_val (has priority over dec)
//   ld_val  - value to load
//   dec     - decrement this digit on the next edge
//   q       - registered digit value
//   is_zero - high while q is 0 (feeds the borrow chain)
// A decrementing digit at 0 rolls to 9. Nibbles A-F are not zero, so they
// simply step down towards 9 like any other non-zero value.
module bcd_down_digit
   import bcd_pkg::*;
(
   input  logic       clk,
   input  logic       clr,
   input  logic       load,
   input  bcd_digit_t ld_val,
   input  logic       dec,
   output bcd_digit_t q,
   output logic       is_zero
);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         q <= BCD_ZERO;
      end else if (load) begin
         q <= ld_val;
      end else if (dec) begin
         q <= (q == BCD_ZERO) ? BCD_MAX : (q - 4'd1);
      end
   end

   assign is_zero = (q == BCD_ZERO);

endmodule

// File: rtl/bcd_down_counter.sv
// Loadable multi-digit BCD down counter with synchronous borrow chain.
// Parameters:
//   DIGITS - number of decades (1..8); count width is 4*DIGITS
//   WRAP   - 1: 0 decrements to all nines with a borrow_out pulse
//            0: the counter holds at zero
// Ports:
//   clk        - clock, rising edge
//   clr        - asynchronous active-high reset
//   en         - decrement by one per cycle while high
//   load       - synchronous load of din (beats en)
//   din        - BCD load value, digit 0 in bits [3:0]
//   q          - registered BCD count
//   zero       - registered, high while q is all zeros
//   done       - one-cycle pulse when a decrement takes q from 1 to 0
//   borrow_out - one-cycle pulse when q wraps from 0 to all nines
//   load_err   - one-cycle pulse when a loaded digit exceeded 9
// Optional build macro BCD_DOWN_LOAD_CHECK_EN: loaded digits above 9 are
// replaced by 9 and flagged on load_err. Without it din loads verbatim and
// load_err is tied low.
module bcd_down_counter
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 4,
   parameter bit          WRAP   = 1'b1
)(
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  en,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   din,
   output logic [4*DIGITS-1:0]   q,
   output logic                  zero,
   output logic                  done,
   output logic                  borrow_out,
   output logic                  load_err
);

   localparam int W = DIGIT_W * DIGITS;

   bcd_digit_t        ld_val [DIGITS];
   logic [DIGITS-1:0] ld_zero;
   logic [DIGITS-1:0] is_zero;
   logic [DIGITS:0]   lower_zero;   // lower_zero[i]: digits 0..i-1 all zero
   logic [DIGITS-1:0] dec;
   logic              all_zero;
   logic              q_is_one;
   logic              count_step;

`ifdef BCD_DOWN_LOAD_CHECK_EN
   logic [DIGITS-1:0] bad_digit;
`endif

   assign lower_zero[0] = 1'b1;
   assign all_zero      = lower_zero[DIGITS];
   assign q_is_one      = (q == W'(1));

   // With WRAP=0 a zero count must not step, so the whole chain is gated.
   assign count_step = en & ~load & (WRAP | ~all_zero);

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
`ifdef BCD_DOWN_LOAD_CHECK_EN
         assign bad_digit[gi] = ~is_bcd_digit(din[gi*DIGIT_W +: DIGIT_W]);
         assign ld_val[gi]    = bad_digit[gi] ? BCD_MAX : din[gi*DIGIT_W +: DIGIT_W];
`else
         assign ld_val[gi]    = din[gi*DIGIT_W +: DIGIT_W];
`endif
         assign ld_zero[gi]        = (ld_val[gi] == BCD_ZERO);
         assign lower_zero[gi + 1] = lower_zero[gi] & is_zero[gi];
         assign dec[gi]            = count_step & lower_zero[gi];

         bcd_down_digit u_digit (
            .clk     (clk),
            .clr     (clr),
            .load    (load),
            .ld_val  (ld_val[gi]),
            .dec     (dec[gi]),
            .q       (q[gi*DIGIT_W +: DIGIT_W]),
            .is_zero (is_zero[gi])
         );
      end
   endgenerate

   // Status flags are computed from the pre-edge count so they line up
   // with the new q on the same edge.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         zero       <= 1'b1;
         done       <= 1'b0;
         borrow_out <= 1'b0;
      end else if (load) begin
         zero       <= &ld_zero;
         done       <= 1'b0;
         borrow_out <= 1'b0;
      end else if (en) begin
         zero       <= all_zero ? ~WRAP : q_is_one;
         done       <= q_is_one;
         borrow_out <= WRAP & all_zero;
      end else begin
         done       <= 1'b0;
         borrow_out <= 1'b0;
      end
   end

`ifdef BCD_DOWN_LOAD_CHECK_EN
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         load_err <= 1'b0;
      end else begin
         load_err <= load & (|bad_digit);
      end
   end
`else
   assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_down_counter.sv
// Bench for bcd_down_counter (DIGITS=4). Two instances: u_wrap (WRAP=1)
// and u_hold (WRAP=0), each with its own count controls and a shared clr.
// The driver pushes the hand-computed post-edge outputs into a queue;
// the monitor pops one entry shortly after every rising edge.
module tb_bcd_down_counter;

   logic        clk = 1'b0;
   logic        clr = 1'b1;
   logic        en1 = 1'b0, load1 = 1'b0;
   logic [15:0] din1 = '0;
   logic        en0 = 1'b0, load0 = 1'b0;
   logic [15:0] din0 = '0;

   logic [15:0] q1, q0;
   logic        zero1, done1, borrow1, lerr1;
   logic        zero0, done0, borrow0, lerr0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          inst;
      logic [15:0] q;
      logic        z;
      logic        d;
      logic        b;
      logic        e;
      string       nm;
   } exp_t;

   exp_t sb[$];

`ifdef BCD_DOWN_LOAD_CHECK_EN
   localparam logic [15:0] A5_LOADED = 16'h0095;
   localparam logic [15:0] A5_NEXT   = 16'h0094;
   localparam logic        A5_ERR    = 1'b1;
`else
   localparam logic [15:0] A5_LOADED = 16'h00A5;
   localparam logic [15:0] A5_NEXT   = 16'h00A4;
   localparam logic        A5_ERR    = 1'b0;
`endif

   always #5 clk = ~clk;

   bcd_down_counter #(.DIGITS(4), .WRAP(1'b1)) u_wrap (
      .clk(clk), .clr(clr), .en(en1), .load(load1), .din(din1),
      .q(q1), .zero(zero1), .done(done1), .borrow_out(borrow1), .load_err(lerr1)
   );

   bcd_down_counter #(.DIGITS(4), .WRAP(1'b0)) u_hold (
      .clk(clk), .clr(clr), .en(en0), .load(load0), .din(din0),
      .q(q0), .zero(zero0), .done(done0), .borrow_out(borrow0), .load_err(lerr0)
   );

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // One cycle of stimulus on one instance; the other instance idles.
   task automatic step(input bit inst, input logic e, input logic l, input logic [15:0] d,
                       input logic [15:0] xq, input logic xz, input logic xd,
                       input logic xb, input logic xe, input string nm);
      exp_t x;
      @(negedge clk);
      if (inst) begin
         en1 = e; load1 = l; din1 = d; en0 = 1'b0; load0 = 1'b0;
      end else begin
         en0 = e; load0 = l; din0 = d; en1 = 1'b0; load1 = 1'b0;
      end
      x = '{inst, xq, xz, xd, xb, xe, nm};
      sb.push_back(x);
      $display("step %-14s inst=%0d en=%b load=%b din=%h exp_q=%h z=%b d=%b b=%b e=%b",
               nm, inst, e, l, d, xq, xz, xd, xb, xe);
   endtask

   // Monitor: compare one expectation per edge, 2 time units after it.
   always @(posedge clk) begin
      exp_t x;
      #2;
      if (sb.size() > 0) begin
         x = sb.pop_front();
         if (x.inst) begin
            chk({x.nm, " q"},      q1,      x.q);
            chk({x.nm, " zero"},   16'(zero1),   16'(x.z));
            chk({x.nm, " done"},   16'(done1),   16'(x.d));
            chk({x.nm, " borrow"}, 16'(borrow1), 16'(x.b));
            chk({x.nm, " lerr"},   16'(lerr1),   16'(x.e));
         end else begin
            chk({x.nm, " q"},      q0,      x.q);
            chk({x.nm, " zero"},   16'(zero0),   16'(x.z));
            chk({x.nm, " done"},   16'(done0),   16'(x.d));
            chk({x.nm, " borrow"}, 16'(borrow0), 16'(x.b));
            chk({x.nm, " lerr"},   16'(lerr0),   16'(x.e));
         end
      end
   end

   logic [15:0] cd_tab [12] = '{16'h0011, 16'h0010, 16'h0009, 16'h0008,
                                16'h0007, 16'h0006, 16'h0005, 16'h0004,
                                16'h0003, 16'h0002, 16'h0001, 16'h0000};

   initial begin
      // Reset held over two edges, then release.
      @(negedge clk);
      @(negedge clk);
      chk("rst q",      q1, 16'h0000);
      chk("rst zero",   16'(zero1), 16'h1);
      chk("rst done",   16'(done1), 16'h0);
      chk("rst borrow", 16'(borrow1), 16'h0);
      chk("rst lerr",   16'(lerr1), 16'h0);
      clr = 1'b0;

      step(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,      "idle");
      step(1, 0, 1, 16'h0357, 16'h0357, 0, 0, 0, 0,      "ld0357");
      step(1, 1, 0, 16'h0000, 16'h0356, 0, 0, 0, 0,      "dec0356");

      // Asynchronous clear in the middle of a cycle, then held over an edge with en.
      @(negedge clk);
      en1 = 1'b0; load1 = 1'b0;
      #1 clr = 1'b1;
      #1;
      chk("aclr q",      q1, 16'h0000);
      chk("aclr zero",   16'(zero1), 16'h1);
      chk("aclr done",   16'(done1), 16'h0);
      chk("aclr borrow", 16'(borrow1), 16'h0);
      en1 = 1'b1;
      @(negedge clk);
      chk("clrheld q",    q1, 16'h0000);
      chk("clrheld zero", 16'(zero1), 16'h1);
      clr = 1'b0;
      en1 = 1'b0;

      step(1, 0, 1, 16'h0012, 16'h0012, 0, 0, 0, 0, "ld0012");
      for (int i = 0; i < 12; i++) begin
         step(1, 1, 0, 16'h0000, cd_tab[i], (i == 11), (i == 11), 0, 0,
              $sformatf("cd%0d", i));
      end
      step(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,      "hold0");
      step(1, 1, 0, 16'h0000, 16'h9999, 0, 0, 1, 0,      "wrap");
      step(1, 0, 0, 16'h0000, 16'h9999, 0, 0, 0, 0,      "holdwrap");
      step(1, 1, 1, 16'h1000, 16'h1000, 0, 0, 0, 0,      "ld1000en");
      step(1, 1, 0, 16'h0000, 16'h0999, 0, 0, 0, 0,      "dec0999");
      step(1, 1, 0, 16'h0000, 16'h0998, 0, 0, 0, 0,      "dec0998");
      step(1, 0, 1, 16'h0002, 16'h0002, 0, 0, 0, 0,      "ld0002");
      step(1, 1, 0, 16'h0000, 16'h0001, 0, 0, 0, 0,      "tog1");
      step(1, 0, 0, 16'h0000, 16'h0001, 0, 0, 0, 0,      "tog0");
      step(1, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0,      "tog1done");
      step(1, 1, 0, 16'h0000, 16'h9999, 0, 0, 1, 0,      "thruwrap");
      step(1, 0, 1, 16'h00A5, A5_LOADED, 0, 0, 0, A5_ERR, "ld00A5");
      step(1, 1, 0, 16'h0000, A5_NEXT, 0, 0, 0, 0,       "decA5");
      step(1, 0, 1, 16'h0001, 16'h0001, 0, 0, 0, 0,      "ld0001");
      step(1, 0, 1, 16'h0000, 16'h0000, 1, 0, 0, 0,      "ld0000");

      // WRAP=0 instance
      step(0, 0, 1, 16'h0001, 16'h0001, 0, 0, 0, 0,      "h_ld0001");
      step(0, 1, 0, 16'h0000, 16'h0000, 1, 1, 0, 0,      "h_done");
      step(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,      "h_stay0");
      step(0, 1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0,      "h_stay0b");
      step(0, 0, 1, 16'h0300, 16'h0300, 0, 0, 0, 0,      "h_ld0300");
      step(0, 1, 0, 16'h0000, 16'h0299, 0, 0, 0, 0,      "h_dec0299");

      @(negedge clk);
      en0 = 1'b0; load0 = 1'b0; en1 = 1'b0; load1 = 1'b0;
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
